// File: rtl/reg_alloc_scheduler_pkg.sv
// Shared core definitions for register renaming: register counts, index types,
// and the allocation scheduler state encoding.
`default_nettype none

package reg_alloc_scheduler_pkg;

  localparam int MIPS_REG_COUNT = 32;
  localparam int PHYS_REG_COUNT = 64;
  localparam int FREE_REG_COUNT = PHYS_REG_COUNT - MIPS_REG_COUNT;

  typedef logic [$clog2(PHYS_REG_COUNT)-1:0] PhysReg;
  typedef logic [$clog2(FREE_REG_COUNT)-1:0] FreeIndex;

  localparam int INFLIGHT_W = $bits(FreeIndex) + 1;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } alloc_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first requester at or
// after the priority pointer, wrapping modulo N_REQ.
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_alloc_scheduler.sv
// Arbitrates rename-lane register requests onto the free list, tracks in-flight
// allocations and blacks out allocation after a restore. Optional REG_ALLOC_STATS_EN adds counters.
`default_nettype none

module reg_alloc_scheduler
  import reg_alloc_scheduler_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      i_req,
  output logic [N_REQ-1:0]      o_gnt,
  output PhysReg                o_gnt_reg,
  output logic                  o_want_reg,
  input  PhysReg                i_free_reg,
  input  logic                  i_commit_free,
  input  logic                  i_restore,
  output logic [INFLIGHT_W-1:0] o_inflight,
  output logic                  o_stall
`ifdef REG_ALLOC_STATS_EN
  ,
  output logic [31:0]           o_stat_grants,
  output logic [31:0]           o_stat_stalls
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD     = CNT_W'(RECOVER_CYCLES - 1);
  // One free-list slot stays empty so allocate never collides with insert.
  localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = INFLIGHT_W'(FREE_REG_COUNT - 1);

  alloc_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [INFLIGHT_W-1:0]   inflight_q, inflight_d;
  logic [N_REQ-1:0]        pick;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    can_grant;
  logic                    grant;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (o_gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    inflight_d = inflight_q;

    can_grant  = rst_n && (state_q == RUN) && !i_restore && (inflight_q < INFLIGHT_MAX);
    o_gnt      = can_grant ? pick : '0;
    grant      = |o_gnt;
    o_want_reg = grant;
    o_gnt_reg  = i_free_reg;
    o_stall    = rst_n && (|i_req) && !grant;

    if (i_restore) begin
      state_d    = RECOVER;
      cnt_d      = CNT_LOAD;
      inflight_d = '0;
    end else begin
      if (state_q == RECOVER) begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      if (grant && !i_commit_free) begin
        inflight_d = inflight_q + 1'b1;
      end else if (!grant && i_commit_free && (inflight_q != '0)) begin
        inflight_d = inflight_q - 1'b1;
      end
      if (grant) begin
        if (gnt_idx == PTR_W'(N_REQ - 1)) ptr_d = '0;
        else                              ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  assign o_inflight = inflight_q;

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (rst_n && i_commit_free && !i_restore && !grant && (inflight_q == '0))
      $display("reg_alloc_scheduler: error: commit with no registers in flight");
  end
`endif

`ifdef REG_ALLOC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stat_grants <= '0;
      o_stat_stalls <= '0;
    end else begin
      if (grant && (o_stat_grants != '1))   o_stat_grants <= o_stat_grants + 1'b1;
      if (o_stall && (o_stat_stalls != '1)) o_stat_stalls <= o_stat_stalls + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_alloc_scheduler.sv
// Randomized scoreboard bench for reg_alloc_scheduler with a cycle-level reference model.
`default_nettype none

module tb_reg_alloc_scheduler;
  import reg_alloc_scheduler_pkg::*;

  localparam int N  = 2;
  localparam int RC = 3;

  logic                  clk;
  logic                  rst_n;
  logic [N-1:0]          i_req;
  logic [N-1:0]          o_gnt;
  PhysReg                o_gnt_reg;
  logic                  o_want_reg;
  PhysReg                i_free_reg;
  logic                  i_commit_free;
  logic                  i_restore;
  logic [INFLIGHT_W-1:0] o_inflight;
  logic                  o_stall;
`ifdef REG_ALLOC_STATS_EN
  logic [31:0]           o_stat_grants;
  logic [31:0]           o_stat_stalls;
`endif

  reg_alloc_scheduler #(
    .N_REQ          (N),
    .RECOVER_CYCLES (RC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req),
    .o_gnt         (o_gnt),
    .o_gnt_reg     (o_gnt_reg),
    .o_want_reg    (o_want_reg),
    .i_free_reg    (i_free_reg),
    .i_commit_free (i_commit_free),
    .i_restore     (i_restore),
    .o_inflight    (o_inflight),
    .o_stall       (o_stall)
`ifdef REG_ALLOC_STATS_EN
    ,
    .o_stat_grants (o_stat_grants),
    .o_stat_stalls (o_stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         stall;
    logic [31:0]  gnt_reg;
    logic [31:0]  inflight;
    logic [31:0]  sg;
    logic [31:0]  ss;
    bit           known;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_inflight = 0;
  int m_ptr      = 0;
  int m_blackout = 0;
  int m_sg       = 0;
  int m_ss       = 0;
  int head       = 0;
  bit m_known    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [N-1:0] req, input bit com, input bit rsto, input bit rn);
    exp_t e;
    int   lane;
    @(posedge clk);
    #1;
    i_req         = req;
    i_commit_free = com;
    i_restore     = rsto;
    rst_n         = rn;
    i_free_reg    = PhysReg'(MIPS_REG_COUNT + head);

    lane = -1;
    if (rn && m_blackout == 0 && !rsto && m_inflight < FREE_REG_COUNT - 1) begin
      for (int k = 0; k < N; k++) begin
        if (lane < 0 && req[(m_ptr + k) % N]) lane = (m_ptr + k) % N;
      end
    end
    e.gnt = '0;
    if (lane >= 0) e.gnt[lane] = 1'b1;
    e.stall    = rn && (req != '0) && (lane < 0);
    e.gnt_reg  = 32'(MIPS_REG_COUNT + head);
    e.inflight = 32'(m_inflight);
    e.sg       = 32'(m_sg);
    e.ss       = 32'(m_ss);
    e.known    = m_known;
    sb.push_back(e);

    if (!rn) begin
      m_inflight = 0;
      m_ptr      = 0;
      m_blackout = 0;
      m_sg       = 0;
      m_ss       = 0;
      m_known    = 1;
    end else begin
      if (lane >= 0) begin
        m_sg++;
        head  = (head + 1) % FREE_REG_COUNT;
        m_ptr = (lane + 1) % N;
      end
      if (e.stall) m_ss++;
      if (rsto) begin
        m_inflight = 0;
        m_blackout = RC;
      end else begin
        if (m_blackout > 0) m_blackout--;
        if (lane >= 0 && !com) m_inflight++;
        else if (lane < 0 && com && m_inflight > 0) m_inflight--;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("gnt", 32'(o_gnt), 32'(e.gnt));
      check("want_reg", 32'(o_want_reg), 32'(|e.gnt));
      check("stall", 32'(o_stall), 32'(e.stall));
      if (e.gnt != '0) check("gnt_reg", 32'(o_gnt_reg), e.gnt_reg);
      if (e.known) begin
        check("inflight", 32'(o_inflight), e.inflight);
`ifdef REG_ALLOC_STATS_EN
        check("stat_grants", o_stat_grants, e.sg);
        check("stat_stalls", o_stat_stalls, e.ss);
`endif
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    i_req         = '0;
    i_commit_free = 1'b0;
    i_restore     = 1'b0;
    i_free_reg    = '0;

    repeat (3) cyc(2'b11, 0, 0, 0);
    repeat (4) cyc(2'b11, 0, 0, 1);
    // Fill to the in-flight ceiling, then stall until a commit frees a slot.
    repeat (FREE_REG_COUNT - 5) cyc(2'b01, 0, 0, 1);
    repeat (2) cyc(2'b01, 0, 0, 1);
    cyc(2'b01, 1, 0, 1);
    cyc(2'b01, 0, 0, 1);
    cyc(2'b01, 0, 0, 1);
    // Restore colliding with request and commit.
    cyc(2'b11, 1, 1, 1);
    repeat (RC + 2) cyc(2'b11, 0, 0, 1);
    // Restore re-asserted during the second recovery cycle.
    cyc(2'b01, 0, 1, 1);
    cyc(2'b01, 0, 0, 1);
    cyc(2'b01, 0, 1, 1);
    repeat (RC + 5) cyc(2'b01, 0, 0, 1);
    cyc(2'b10, 1, 0, 1);
    cyc(2'b10, 1, 0, 1);
    // Commit with nothing in flight.
    cyc(2'b00, 0, 1, 1);
    cyc(2'b00, 1, 0, 1);
    cyc(2'b00, 1, 0, 1);
    // Reset in the middle of recovery.
    repeat (RC + 1) cyc(2'b00, 0, 0, 1);
    cyc(2'b11, 0, 1, 1);
    cyc(2'b11, 0, 0, 1);
    cyc(2'b11, 0, 0, 0);
    repeat (3) cyc(2'b11, 0, 0, 1);

    for (int n = 0; n < 800; n++) begin
      cyc(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 199) != 0));
    end
    for (int n = 0; n < 300; n++) begin
      cyc(N'($urandom), $urandom_range(0, 1) == 1, ($urandom_range(0, 29) == 0), 1'b1);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_alloc_scheduler.md
REG_ALLOC_SCHEDULER -- requirements
Module: reg_alloc_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of rename lanes requesting physical registers.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 1, cycles of allocation blackout after a restore.
REQ-003 SHALL have ports clk in 1, clock; rst_n in 1, reset (synchronous, active-low).
REQ-004 SHALL have i_req in N_REQ, per-lane request for one physical register this cycle.
REQ-005 SHALL have o_gnt out N_REQ, one-hot grant, combinational, at most one bit set.
REQ-006 SHALL have o_gnt_reg out PhysReg, register granted, valid when o_gnt nonzero.
REQ-007 SHALL have o_want_reg out 1, allocation pulse to the free list, equal to |o_gnt.
REQ-008 SHALL have i_free_reg in PhysReg, head of the free list, passed through to o_gnt_reg.
REQ-009 SHALL have i_commit_free in 1, commit stage returning one register to the free list this cycle.
REQ-010 SHALL have i_restore in 1, flush from the hazard controller, forwarded unchanged to the free list.
REQ-011 SHALL have o_inflight out FreeIndex+1 bits, count of allocated-but-uncommitted registers.
REQ-012 SHALL have o_stall out 1, high when any i_req bit is high and o_gnt is zero.

Function
REQ-013 SHALL implement FSM states RUN and RECOVER; reset state RUN.
REQ-014 SHALL in RUN grant when i_restore=0 and o_inflight < FREE_REG_COUNT-1 (one slot always kept empty so allocate never meets insert).
REQ-015 SHALL select the granted lane round-robin, starting the search at priority pointer rr_ptr and wrapping modulo N_REQ.
REQ-016 SHALL advance rr_ptr to (granted lane + 1) mod N_REQ on each grant and hold it otherwise.
REQ-017 SHALL issue zero grants in RECOVER and in any cycle with i_restore=1.
REQ-018 SHALL on i_restore=1 enter RECOVER, load recover counter with RECOVER_CYCLES-1, then decrement each cycle, returning to RUN the cycle after it reads zero.
REQ-019 SHALL restart the recover counter if i_restore reasserts while in RECOVER.
REQ-020 SHALL update o_inflight: +1 on grant, -1 on i_commit_free, unchanged on both, cleared to 0 on i_restore regardless of grant or commit.
REQ-021 SHALL never decrement o_inflight below 0; a commit at 0 leaves 0 (SIMULATION builds print an error).
REQ-022 SHALL never exceed FREE_REG_COUNT-1 on o_inflight.
REQ-023 SHALL keep a grant with simultaneous commit at o_inflight = FREE_REG_COUNT-2 legal; the limit check uses the registered count only.

Reset
REQ-024 SHALL on rst_n=0 set state RUN, rr_ptr 0, o_inflight 0, recover counter 0.
REQ-025 SHALL drive o_gnt 0, o_want_reg 0, o_stall 0 during reset cycles irrespective of i_req.
REQ-026 SHALL abandon RECOVER immediately when reset asserts mid-recovery.

Configuration
REQ-027 SHALL with REG_ALLOC_STATS_EN defined add outputs o_stat_grants and o_stat_stalls, 32 bits each, saturating, cleared by reset, counting grant cycles and o_stall cycles.
REQ-028 SHALL without REG_ALLOC_STATS_EN omit these ports and counters entirely; other behaviour is identical.

Structure
REQ-029 SHALL take PhysReg, FreeIndex, FREE_REG_COUNT, MIPS_REG_COUNT from the shared core package; add the FSM state enum there.
REQ-030 SHALL place the round-robin picker in a sub-module rr_picker (request vector and pointer in, one-hot out), purely combinational.
REQ-031 SHALL sit between the rename lanes and register_free_list, driving its i_want_reg and consuming its o_free_reg.

Verification
REQ-032 After reset, i_req=2'b11 for 4 cycles -> grants 01,10,01,10; o_gnt_reg follows the free-list head 32,33,34,35; o_inflight=4.
REQ-033 o_inflight at FREE_REG_COUNT-1, i_req=01, no commit -> o_gnt=0, o_stall=1; next cycle commit -> grant the following cycle.
REQ-034 i_restore with grant request and commit same cycle -> no grant, o_inflight=0 next cycle, RECOVER for RECOVER_CYCLES, first grant the following cycle.
REQ-035 RECOVER_CYCLES=3, restore reasserted in second RECOVER cycle -> three further blackout cycles counted from the new restore.
REQ-036 Grant and commit same cycle at o_inflight=5 -> o_inflight stays 5; commit at 0 -> stays 0, error printed.
REQ-037 REG_ALLOC_STATS_EN, 10 grants and 3 stalls -> o_stat_grants=10, o_stat_stalls=3; reset clears both.
